i2s_tx: RTL
===========

# i2s_tx

Stereo I2S transmitter (Philips format, bus master) on the Hazard2 SoC's audio path; the output-side counterpart of the I2S microphone receiver. Software or DMA pushes PCM frames into a small FIFO. The block generates `sck` and `ws` from `HCLK` and serialises each sample MSB-first onto `sd` for a DAC or codec.

## Interface
Parameters:
- `DATA_W`, 16: sample width; must be ≤ `SLOT_W`-1.
- `SLOT_W`, 32: `sck` periods per channel slot.
- `CLK_DIV`, 4: `HCLK` cycles per `sck` half-period; must be ≥ 2.
- `FIFO_DEPTH`, 4: frame FIFO depth; must be a power of two.

Ports:
- `HCLK`, input, 1: the only clock.
- `HRESET`, input, 1: **synchronous, active-high** reset.
- `en`, input, 1: run request.
- `push_valid`, input, 1: frame write strobe.
- `push_ready`, output, 1: FIFO not full.
- `left`, input, `DATA_W`: left sample (two's complement).
- `right`, input, `DATA_W`: right sample; ignored when `I2S_TX_MONO_EN` is defined.
- `level`, output, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `underrun`, output, 1: one-`HCLK` pulse when a frame starts with the FIFO empty.
- `sck`, output, 1: bit clock.
- `ws`, output, 1: word select; 0 = left, 1 = right.
- `sd`, output, 1: serial data.

## Operation
- **FIFO**
  - A push occurs when `push_valid && push_ready`.
  - `push_ready = !full`, computed from registered occupancy. A push at full is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves `level` unchanged.
- **State machine: IDLE and RUN**
  - IDLE: `sck`=0, `ws`=0, `sd`=0; divider and bit counter are held at 0.
  - IDLE→RUN on the first cycle `en`=1. In that same cycle the block loads a frame and sets bit counter `bc`=0.
  - RUN→IDLE at the frame boundary where `bc` would wrap while `en`=0. The current frame always completes.
- **Frame load**
  - If the FIFO is non-empty: pop one entry into the left and right shift registers.
  - If the FIFO is empty: load zeros and pulse `underrun`.
- **Divider**
  - Counter runs 0..`CLK_DIV`-1.
  - On wrap, `sck` toggles.
  - A 1→0 toggle is a *falling event*.
- **Falling event**
  - `bc` increments mod 2·`SLOT_W`.
  - `ws`, `sd` and the shift registers update.
  - When `bc` wraps to 0, the next frame is loaded in the same cycle.
- **Slot layout** (slot position p = `bc` mod `SLOT_W`)
  - `ws` = `bc` ≥ `SLOT_W`.
  - p=0: `sd`=0. This is the Philips one-bit delay after the `ws` edge.
  - p=1..`DATA_W`: sample bits MSB..LSB.
  - p>`DATA_W`: `sd`=0 (padding).
- **Reset**
  - `HRESET` has priority over every other input, including mid-frame.
  - Return to IDLE, flush the FIFO (`level`=0), clear both shift registers.
  - Drop any partially sent frame. No `underrun` pulse is generated by reset.

## Timing
- Reset values: `sck`=0, `ws`=0, `sd`=0, `underrun`=0, `level`=0, `push_ready`=1.
- `level` updates in the cycle after a push or pop.
- `push_ready` deasserts in the cycle after the push that fills the FIFO.
- `sck` period = 2·`CLK_DIV` `HCLK` cycles (defaults: 8).
- Frame period = 2·`SLOT_W`·2·`CLK_DIV` cycles (defaults: 512).
- First `sck` rise occurs `CLK_DIV` cycles after IDLE→RUN.
- `ws` and `sd` change only on falling events, except at frame load on RUN entry. They are therefore stable around every `sck` rising edge.
- `underrun` is asserted in the same cycle as the frame load.
- A push into an empty FIFO is visible to a frame load no earlier than the following cycle.

## Configuration
- Macro: `I2S_TX_MONO_EN`.
- Defined:
  - Each FIFO entry holds only `left`, so the FIFO storage width is `DATA_W`.
  - The frame load copies that sample into both the left and right shift registers.
  - `right` is unused.
- Undefined:
  - Full stereo; FIFO entries are 2·`DATA_W` wide.

## Test plan
- **Basic frame.** Defaults, reset, push L=16'hA5F0 / R=16'h0FF1, then `en`=1.
  - Sample `sd` on `sck` rises: 0, then A5F0 MSB-first, then 15 zeros with `ws`=0.
  - Then 0, 0FF1, 15 zeros with `ws`=1.
  - No `underrun`; `level` goes 1→0 in the cycle after the load.
- **Underrun.** `en`=1 with the FIFO empty.
  - All `sd` bits are 0.
  - `underrun` pulses exactly once per 512 cycles.
- **Full FIFO.** Four pushes with `en`=0.
  - `level`=4, `push_ready`=0.
  - A fifth push with a same-cycle pop is refused, and `level` stays at 3 after the pop.
- **Stop request.** Drop `en` mid-frame.
  - The frame completes; IDLE is reached at the boundary with `sck`=`ws`=`sd`=0.
  - The next frame is not popped.
- **Reset mid-operation.** Assert `HRESET` at `bc`=40 with `level`=2.
  - The next cycle shows all reset values and `level`=0.
  - With `en` held high, restart begins at `bc`=0 with no stale bits.
- **Mono.** With `I2S_TX_MONO_EN` defined, push L=16'h8001.
  - Both slots carry 8001.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S bus master; frames are popped from a small FIFO and shifted MSB-first onto sd.
// Define I2S_TX_MONO_EN to store only `left` per entry and send it in both slots.

module i2s_tx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdat,
  input  logic          pop,
  output logic [W-1:0]  rdat,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  assign rdat  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
endmodule

module i2s_tx #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        en,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [DATA_W-1:0]           left,
  input  logic [DATA_W-1:0]           right,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  output logic                        sck,
  output logic                        ws,
  output logic                        sd
);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW  = $clog2(2 * SLOT_W);
  localparam int DIVW = $clog2(CLK_DIV);
`ifdef I2S_TX_MONO_EN
  localparam int FW = DATA_W;
`else
  localparam int FW = 2 * DATA_W;
`endif
  localparam logic [BCW-1:0]  BC_LAST  = BCW'(2 * SLOT_W - 1);
  localparam logic [BCW-1:0]  SLOT_BC  = BCW'(SLOT_W);
  localparam logic [BCW-1:0]  L_LAST   = BCW'(DATA_W);
  localparam logic [BCW-1:0]  R_FIRST  = BCW'(SLOT_W + 1);
  localparam logic [BCW-1:0]  R_LAST   = BCW'(SLOT_W + DATA_W);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [DIVW-1:0]   div_cnt, div_n;
  logic [BCW-1:0]    bc, bc_n, bc_inc;
  logic              sck_n, ws_n, sd_n;
  logic [DATA_W-1:0] sh_l, sh_r, shl_n, shr_n;
  logic              load;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_wdat, fifo_rdat;

`ifdef I2S_TX_MONO_EN
  logic unused_right;
  assign unused_right = ^right;
  assign fifo_wdat    = left;
`else
  assign fifo_wdat = {left, right};
`endif

  assign push_ready = !fifo_full;
  assign fifo_push  = push_valid && push_ready;
  // A frame load pops when data exists, otherwise it sends silence and flags it.
  assign fifo_pop   = load && !fifo_empty && !HRESET;
  assign underrun   = load && fifo_empty && !HRESET;

  i2s_tx_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (fifo_push),
    .wdat  (fifo_wdat),
    .pop   (fifo_pop),
    .rdat  (fifo_rdat),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    sck_n   = sck;
    bc_n    = bc;
    ws_n    = ws;
    sd_n    = sd;
    shl_n   = sh_l;
    shr_n   = sh_r;
    load    = 1'b0;
    bc_inc  = bc + BCW'(1);
    case (state)
      IDLE: begin
        div_n = '0;
        sck_n = 1'b0;
        bc_n  = '0;
        ws_n  = 1'b0;
        sd_n  = 1'b0;
        if (en) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + DIVW'(1);
        end else begin
          div_n = '0;
          sck_n = ~sck;
          if (sck) begin
            // Falling event: advance one bit; slot position 0 is the Philips delay bit.
            ws_n = 1'b0;
            sd_n = 1'b0;
            if (bc == BC_LAST) begin
              bc_n = '0;
              if (en) load = 1'b1;
              else    state_n = IDLE;
            end else begin
              bc_n = bc_inc;
              ws_n = (bc_inc >= SLOT_BC);
              if (bc_inc <= L_LAST) begin
                sd_n  = sh_l[DATA_W-1];
                shl_n = sh_l << 1;
              end else if (bc_inc >= R_FIRST && bc_inc <= R_LAST) begin
                sd_n  = sh_r[DATA_W-1];
                shr_n = sh_r << 1;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      if (fifo_empty) begin
        shl_n = '0;
        shr_n = '0;
      end else begin
`ifdef I2S_TX_MONO_EN
        shl_n = fifo_rdat;
        shr_n = fifo_rdat;
`else
        shl_n = fifo_rdat[FW-1:DATA_W];
        shr_n = fifo_rdat[DATA_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      div_cnt <= '0;
      sck     <= 1'b0;
      bc      <= '0;
      ws      <= 1'b0;
      sd      <= 1'b0;
      sh_l    <= '0;
      sh_r    <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      sck     <= sck_n;
      bc      <= bc_n;
      ws      <= ws_n;
      sd      <= sd_n;
      sh_l    <= shl_n;
      sh_r    <= shr_n;
    end
  end
endmodule
